// File: rtl/sdram_pkg.sv
// Shared types and address-field widths for the SDRAM front-side cache.
package sdram_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned OFF_W  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_FILL_REQ,
      S_FILL_WAIT,
      S_WR_REQ,
      S_WR_WAIT,
      S_ACK,
      S_FLUSH
   } state_t;

   // Tag bits left after removing the index and the byte offset.
   function automatic int unsigned tag_width(input int unsigned aw, input int unsigned iw);
      return aw - iw - OFF_W;
   endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle; dat_i carries master-to-slave data, dat_o slave-to-master.
interface if_wb #(
   parameter int unsigned AWIDTH = 26
) ();
   logic              cyc;
   logic              stb;
   logic              we;
   logic [AWIDTH-1:0] adr;
   logic [3:0]        sel;
   logic [31:0]       dat_i;
   logic [31:0]       dat_o;
   logic              ack;
   logic              stall;

   modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack, stall);
   modport slave  (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack, stall);
endinterface

// File: rtl/dp_ram.sv
// Line store holding {tag, data}: registered read, byte-enabled data write.
module dp_ram
   import sdram_pkg::*;
#(
   parameter int unsigned IWIDTH = 8,
   parameter int unsigned TWIDTH = 16
) (
   input  logic              clk_i,
   input  logic              rd_en_i,
   input  logic [IWIDTH-1:0] rd_idx_i,
   input  logic              wr_en_i,
   input  logic [IWIDTH-1:0] wr_idx_i,
   input  logic [SEL_W-1:0]  wr_be_i,
   input  logic [TWIDTH-1:0] wr_tag_i,
   input  logic [WORD_W-1:0] wr_data_i,
   output logic [TWIDTH-1:0] rd_tag_o,
   output logic [WORD_W-1:0] rd_data_o
);
   localparam int unsigned LINES = 1 << IWIDTH;

   logic [TWIDTH-1:0]      tag_mem_q  [LINES];
   logic [SEL_W-1:0][7:0]  data_mem_q [LINES];
   logic [TWIDTH-1:0]      rd_tag_q;
   logic [WORD_W-1:0]      rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_mem_q[wr_idx_i] <= wr_tag_i;
         for (int b = 0; b < int'(SEL_W); b++) begin
            if (wr_be_i[b]) data_mem_q[wr_idx_i][b] <= wr_data_i[8*b +: 8];
         end
      end
      if (rd_en_i) begin
         rd_tag_q  <= tag_mem_q[rd_idx_i];
         rd_data_q <= data_mem_q[rd_idx_i];
      end
   end

   assign rd_tag_o  = rd_tag_q;
   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sdram_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache between the CPU
// Wishbone port and the SDRAM controller.
module sdram_cache
   import sdram_pkg::*;
#(
   parameter int unsigned AWIDTH = 26,
   parameter int unsigned IWIDTH = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   if_wb.slave  cpu,
   if_wb.master mem,
   input  logic flush_i
);
   localparam int unsigned TAG_W = tag_width(AWIDTH, IWIDTH);
   localparam int unsigned LINES = 1 << IWIDTH;

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   adr_q, adr_d;
   logic                we_q, we_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [WORD_W-1:0]   dat_q, dat_d;
   logic                abort_q, abort_d;
   logic                flush_pend_q, flush_pend_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic                ack_q, ack_d;
   logic [WORD_W-1:0]   cpu_dat_q, cpu_dat_d;
   logic                m_cyc_q, m_cyc_d;
   logic                m_stb_q, m_stb_d;
   logic                m_we_q, m_we_d;
   logic [AWIDTH-1:0]   m_adr_q, m_adr_d;
   logic [SEL_W-1:0]    m_sel_q, m_sel_d;
   logic [WORD_W-1:0]   m_dat_q, m_dat_d;

   logic                stall_c, accept_c, line_hit_c, flush_req_c;
   logic [IWIDTH-1:0]   idx_c;
   logic [TAG_W-1:0]    tag_c;
   state_t              ret_state_c;
   logic                ram_rd_en_c, ram_wr_en_c;
   logic [SEL_W-1:0]    ram_wr_be_c;
   logic [WORD_W-1:0]   ram_wr_data_c;
   logic [TAG_W-1:0]    ram_rd_tag;
   logic [WORD_W-1:0]   ram_rd_data;

   assign stall_c     = (state_q != S_IDLE) | flush_i;
   assign accept_c    = cpu.cyc & cpu.stb & ~stall_c;
   assign idx_c       = adr_q[IWIDTH+1:OFF_W];
   assign tag_c       = adr_q[AWIDTH-1:IWIDTH+2];
   assign line_hit_c  = valid_q[idx_c] & (ram_rd_tag == tag_c);
   assign flush_req_c = flush_pend_q | flush_i;
   // A flush seen while busy is serviced before the bus is reopened.
   assign ret_state_c = flush_req_c ? S_FLUSH : S_IDLE;

   always_comb begin
      state_d       = state_q;
      adr_d         = adr_q;
      we_d          = we_q;
      sel_d         = sel_q;
      dat_d         = dat_q;
      flush_pend_d  = flush_pend_q;
      valid_d       = valid_q;
      ack_d         = 1'b0;
      cpu_dat_d     = cpu_dat_q;
      m_cyc_d       = m_cyc_q;
      m_stb_d       = m_stb_q;
      m_we_d        = m_we_q;
      m_adr_d       = m_adr_q;
      m_sel_d       = m_sel_q;
      m_dat_d       = m_dat_q;
      ram_rd_en_c   = 1'b0;
      ram_wr_en_c   = 1'b0;
      ram_wr_be_c   = '1;
      ram_wr_data_c = mem.dat_o;
      // Dropping cyc mid-transaction suppresses the eventual cpu ack only.
      abort_d       = abort_q | ((state_q != S_IDLE) & ~cpu.cyc);

      if (flush_i && state_q != S_IDLE && state_q != S_FLUSH) flush_pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (flush_i) begin
               state_d = S_FLUSH;
            end else if (accept_c) begin
               adr_d       = cpu.adr;
               we_d        = cpu.we;
               sel_d       = cpu.sel;
               dat_d       = cpu.dat_i;
               abort_d     = 1'b0;
               ram_rd_en_c = 1'b1;
               if (cpu.we) begin
                  state_d = S_WR_REQ;
                  m_cyc_d = 1'b1;
                  m_stb_d = 1'b1;
                  m_we_d  = 1'b1;
                  m_adr_d = cpu.adr;
                  m_sel_d = cpu.sel;
                  m_dat_d = cpu.dat_i;
               end else begin
                  state_d = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            if (line_hit_c && (&sel_q)) begin
               ack_d     = ~abort_d;
               cpu_dat_d = ram_rd_data;
               state_d   = ret_state_c;
            end else begin
               state_d = S_FILL_REQ;
               m_cyc_d = 1'b1;
               m_stb_d = 1'b1;
               m_we_d  = 1'b0;
               m_adr_d = adr_q;
               m_sel_d = '1;
            end
         end
         S_FILL_REQ: begin
            if (!mem.stall) begin
               m_stb_d = 1'b0;
               state_d = S_FILL_WAIT;
            end
         end
         S_FILL_WAIT: begin
            if (mem.ack) begin
               m_cyc_d   = 1'b0;
               cpu_dat_d = mem.dat_o;
               ack_d     = ~abort_d;
               state_d   = S_ACK;
               // Partial-width reads bypass the line.
               if (&sel_q) begin
                  ram_wr_en_c    = 1'b1;
                  valid_d[idx_c] = 1'b1;
               end
            end
         end
         S_WR_REQ: begin
            if (!mem.stall) begin
               m_stb_d = 1'b0;
               state_d = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (mem.ack) begin
               m_cyc_d = 1'b0;
               ack_d   = ~abort_d;
               state_d = S_ACK;
               if (line_hit_c) begin
                  ram_wr_en_c   = 1'b1;
                  ram_wr_be_c   = sel_q;
                  ram_wr_data_c = dat_q;
               end
            end
         end
         S_ACK: begin
            state_d = ret_state_c;
         end
         S_FLUSH: begin
            valid_d      = '0;
            flush_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         adr_q        <= '0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         dat_q        <= '0;
         abort_q      <= 1'b0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
         ack_q        <= 1'b0;
         cpu_dat_q    <= '0;
         m_cyc_q      <= 1'b0;
         m_stb_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_adr_q      <= '0;
         m_sel_q      <= '0;
         m_dat_q      <= '0;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         dat_q        <= dat_d;
         abort_q      <= abort_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
         ack_q        <= ack_d;
         cpu_dat_q    <= cpu_dat_d;
         m_cyc_q      <= m_cyc_d;
         m_stb_q      <= m_stb_d;
         m_we_q       <= m_we_d;
         m_adr_q      <= m_adr_d;
         m_sel_q      <= m_sel_d;
         m_dat_q      <= m_dat_d;
      end
   end

   dp_ram #(
      .IWIDTH (IWIDTH),
      .TWIDTH (TAG_W)
   ) u_ram (
      .clk_i     (clk_i),
      .rd_en_i   (ram_rd_en_c),
      .rd_idx_i  (cpu.adr[IWIDTH+1:OFF_W]),
      .wr_en_i   (ram_wr_en_c),
      .wr_idx_i  (idx_c),
      .wr_be_i   (ram_wr_be_c),
      .wr_tag_i  (tag_c),
      .wr_data_i (ram_wr_data_c),
      .rd_tag_o  (ram_rd_tag),
      .rd_data_o (ram_rd_data)
   );

   assign cpu.stall = stall_c;
   assign cpu.ack   = ack_q;
   assign cpu.dat_o = cpu_dat_q;
   assign mem.cyc   = m_cyc_q;
   assign mem.stb   = m_stb_q;
   assign mem.we    = m_we_q;
   assign mem.adr   = m_adr_q;
   assign mem.sel   = m_sel_q;
   assign mem.dat_i = m_dat_q;
endmodule

// File: tb/tb_sdram_cache.sv
// Scoreboard bench for sdram_cache: directed CPU traffic against a scripted SDRAM responder.
module tb_sdram_cache;
   localparam int unsigned AW = 26;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   always #5 clk = ~clk;

   if_wb #(.AWIDTH(AW)) cpu_bus ();
   if_wb #(.AWIDTH(AW)) mem_bus ();

   sdram_cache #(.AWIDTH(AW), .IWIDTH(8)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .cpu     (cpu_bus),
      .mem     (mem_bus),
      .flush_i (flush)
   );

   typedef struct {
      logic [31:0] data;
      bit          chk;
   } cpu_exp_t;

   typedef struct {
      logic [AW-1:0] adr;
      logic          we;
      logic [3:0]    sel;
      logic [31:0]   dat;
   } mem_exp_t;

   cpu_exp_t    cpu_q[$];
   mem_exp_t    mem_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc_cnt = 0;
   int          mem_req_cnt = 0;
   int          last_ack_cyc = 0;
   logic [31:0] mem_rdata = 32'h0;
   bit          mem_hold = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc_cnt++;

   // CPU-side monitor: every ack must match the oldest expected response.
   always @(negedge clk) begin
      if (!rst && cpu_bus.ack) begin
         last_ack_cyc = cyc_cnt;
         if (cpu_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected cpu ack: got data %0h, expected no ack", cpu_bus.dat_o);
         end else begin
            cpu_exp_t e;
            e = cpu_q.pop_front();
            if (e.chk) check("cpu rdata", 64'(cpu_bus.dat_o), 64'(e.data));
         end
      end
   end

   // Memory-side monitor: every accepted mem request must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && mem_bus.cyc && mem_bus.stb && !mem_bus.stall) begin
         mem_req_cnt++;
         if (mem_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected mem req: got adr %0h we %0b, expected none", mem_bus.adr, mem_bus.we);
         end else begin
            mem_exp_t e;
            e = mem_q.pop_front();
            check("mem adr", 64'(mem_bus.adr), 64'(e.adr));
            check("mem we", 64'(mem_bus.we), 64'(e.we));
            check("mem sel", 64'(mem_bus.sel), 64'(e.sel));
            if (e.we) check("mem wdata", 64'(mem_bus.dat_i), 64'(e.dat));
         end
      end
   end

   // SDRAM responder: ack one cycle after a request is accepted, unless held.
   initial begin
      mem_bus.ack   = 1'b0;
      mem_bus.dat_o = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst && mem_bus.cyc && mem_bus.stb && !mem_bus.stall && !mem_hold) begin
            @(negedge clk);
            mem_bus.ack   = 1'b1;
            mem_bus.dat_o = mem_rdata;
            @(negedge clk);
            mem_bus.ack   = 1'b0;
         end
      end
   end

   task automatic push_mem(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
      mem_exp_t e;
      e.adr = adr; e.we = we; e.sel = sel; e.dat = dat;
      mem_q.push_back(e);
   endtask

   task automatic push_cpu(input logic [31:0] data, input bit chk);
      cpu_exp_t e;
      e.data = data; e.chk = chk;
      cpu_q.push_back(e);
   endtask

   task automatic issue(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input bit with_flush,
                        output int acc_cyc, output bit first_stall);
      bit acc;
      acc = 1'b0;
      acc_cyc = 0;
      first_stall = 1'b0;
      @(posedge clk); #1;
      cpu_bus.cyc = 1'b1; cpu_bus.stb = 1'b1; cpu_bus.we = we;
      cpu_bus.adr = adr; cpu_bus.sel = sel; cpu_bus.dat_i = dat;
      if (with_flush) flush = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (i == 0) first_stall = cpu_bus.stall;
         if (!cpu_bus.stall) begin
            acc = 1'b1;
            acc_cyc = cyc_cnt;
         end
         @(posedge clk); #1;
         flush = 1'b0;
      end
      cpu_bus.stb = 1'b0;
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL accept timeout: got stall held 50 cycles, expected acceptance");
      end
   endtask

   task automatic wait_ack(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk);
         if (cpu_q.size() == 0) done = 1'b1;
      end
      #1 cpu_bus.cyc = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s ack timeout: got no ack in 60 cycles, expected ack", name);
         cpu_q.delete();
      end
   endtask

   task automatic do_read(input string name, input logic [AW-1:0] adr, input logic [3:0] sel,
                          input bit miss, input logic [31:0] rdata, input logic [31:0] exp,
                          input bit with_flush);
      int m0, acc;
      bit fs;
      m0 = mem_req_cnt;
      mem_rdata = rdata;
      if (miss) push_mem(adr, 1'b0, 4'hf, 32'h0);
      push_cpu(exp, 1'b1);
      issue(adr, 1'b0, sel, 32'h0, with_flush, acc, fs);
      wait_ack(name);
      check({name, " mem reqs"}, 64'(mem_req_cnt - m0), miss ? 64'd1 : 64'd0);
      if (!miss) check({name, " hit latency"}, 64'(last_ack_cyc - acc), 64'd2);
      if (with_flush) check({name, " flush stall"}, 64'(fs), 64'd1);
   endtask

   task automatic do_write(input string name, input logic [AW-1:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
      int m0, acc;
      bit fs;
      m0 = mem_req_cnt;
      push_mem(adr, 1'b1, sel, dat);
      push_cpu(32'h0, 1'b0);
      issue(adr, 1'b1, sel, dat, 1'b0, acc, fs);
      wait_ack(name);
      check({name, " mem reqs"}, 64'(mem_req_cnt - m0), 64'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " mem.cyc"},   64'(mem_bus.cyc),   64'd0);
      check({tag, " mem.stb"},   64'(mem_bus.stb),   64'd0);
      check({tag, " mem.we"},    64'(mem_bus.we),    64'd0);
      check({tag, " mem.adr"},   64'(mem_bus.adr),   64'd0);
      check({tag, " mem.dat_i"}, 64'(mem_bus.dat_i), 64'd0);
      check({tag, " cpu.ack"},   64'(cpu_bus.ack),   64'd0);
      check({tag, " cpu.dat_o"}, 64'(cpu_bus.dat_o), 64'd0);
   endtask

   initial begin
      int acc;
      bit fs, seen;
      rst = 1'b1; flush = 1'b0;
      cpu_bus.cyc = 1'b0; cpu_bus.stb = 1'b0; cpu_bus.we = 1'b0;
      cpu_bus.adr = '0; cpu_bus.sel = 4'h0; cpu_bus.dat_i = 32'h0;
      mem_bus.stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;

      do_read("cold read", 26'h0000100, 4'hf, 1'b1, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0);
      do_read("read hit", 26'h0000100, 4'hf, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0);
      do_write("partial write", 26'h0000100, 4'b0011, 32'h00001234);
      do_read("merged hit", 26'h0000100, 4'hf, 1'b0, 32'h0, 32'hCAFE1234, 1'b0);
      do_read("conflict 500", 26'h0000500, 4'hf, 1'b1, 32'h55AA0500, 32'h55AA0500, 1'b0);
      do_read("conflict 100", 26'h0000100, 4'hf, 1'b1, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0);
      do_read("flush+read", 26'h0000500, 4'hf, 1'b1, 32'h55AA0500, 32'h55AA0500, 1'b1);
      do_read("refill hit", 26'h0000500, 4'hf, 1'b0, 32'h0, 32'h55AA0500, 1'b0);
      do_read("bypass byte", 26'h0000900, 4'h1, 1'b1, 32'h11223344, 32'h11223344, 1'b0);
      do_read("after bypass", 26'h0000500, 4'hf, 1'b0, 32'h0, 32'h55AA0500, 1'b0);

      // Standalone flush pulse drops the line.
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      repeat (2) @(posedge clk);
      do_read("post flush", 26'h0000500, 4'hf, 1'b1, 32'h55AA0500, 32'h55AA0500, 1'b0);

      // Request held off by mem.stall must stay stable.
      @(posedge clk); #1 mem_bus.stall = 1'b1;
      mem_rdata = 32'hDEAD0800;
      push_mem(26'h0000800, 1'b0, 4'hf, 32'h0);
      push_cpu(32'hDEAD0800, 1'b1);
      issue(26'h0000800, 1'b0, 4'hf, 32'h0, 1'b0, acc, fs);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_bus.stb) seen = 1'b1;
      end
      check("stall stb seen", 64'(seen), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall stb", 64'(mem_bus.stb), 64'd1);
         check("stall adr", 64'(mem_bus.adr), 64'h800);
      end
      @(posedge clk); #1 mem_bus.stall = 1'b0;
      wait_ack("stalled read");

      // Reset while the fill is outstanding.
      mem_hold = 1'b1;
      push_mem(26'h0000100, 1'b0, 4'hf, 32'h0);
      issue(26'h0000100, 1'b0, 4'hf, 32'h0, 1'b0, acc, fs);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mem_bus.cyc && !mem_bus.stb) seen = 1'b1;
      end
      check("reached fill wait", 64'(seen), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check_idle_outputs("mid reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; mem_hold = 1'b0; cpu_bus.cyc = 1'b0;
      do_read("reset inval 800", 26'h0000800, 4'hf, 1'b1, 32'hDEAD0800, 32'hDEAD0800, 1'b0);
      do_read("reset inval 500", 26'h0000500, 4'hf, 1'b1, 32'h55AA0500, 32'h55AA0500, 1'b0);

      // cyc dropped mid-read: fill still lands, no cpu ack.
      mem_rdata = 32'hCAFEBABE;
      push_mem(26'h0000100, 1'b0, 4'hf, 32'h0);
      issue(26'h0000100, 1'b0, 4'hf, 32'h0, 1'b0, acc, fs);
      cpu_bus.cyc = 1'b0;
      repeat (10) @(posedge clk);
      do_read("after abort", 26'h0000100, 4'hf, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0);

      repeat (3) @(posedge clk);
      check("cpu queue drained", 64'(cpu_q.size()), 64'd0);
      check("mem queue drained", 64'(mem_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
